// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: main + skid entry under valid/ready.
// Flush turns the stage into a bubble, and a saturating counter tracks stall cycles.
module pipe_stage_reg #(
    parameter int                  DATA_W      = 64,
    parameter int                  CTRL_W      = 16,
    parameter logic [DATA_W-1:0]   BUBBLE_DATA = '0,
    parameter int                  CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high (and en is high). in_ready and out_valid are registered and never depend
    // combinationally on the opposite side of the stage.

    // State encoding is {main_v, skid_v}; 2'b01 cannot be reached.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic acc;
    logic fire;
    logic stalled;

    assign acc     = en & in_valid & in_ready_q & ~flush;
    assign fire    = en & main_v_q & out_ready;
    assign stalled = en & main_v_q & ~out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_data_d = BUBBLE_DATA;
            main_ctrl_d = '0;
        end else begin
            case ({main_v_q, skid_v_q})
                ST_EMPTY: begin
                    if (acc) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (fire && acc) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (fire) begin
                        main_v_d    = 1'b0;
                        main_data_d = BUBBLE_DATA;
                        main_ctrl_d = '0;
                    end else if (acc) begin
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        skid_v_d    = 1'b0;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    main_v_d    = 1'b0;
                    skid_v_d    = 1'b0;
                    main_data_d = BUBBLE_DATA;
                    main_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d = ~skid_v_d;

        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= BUBBLE_DATA;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign stall_cnt = stall_cnt_q;
    assign dbg_state = {main_v_q, skid_v_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, flush, freeze
// and stall-counter saturation, with hand-computed expected values.
module tb_pipe_stage_reg;

    localparam int               DATA_W = 16;
    localparam int               CTRL_W = 8;
    localparam int               CNT_W  = 4;
    localparam logic [DATA_W-1:0] BUBBLE = 16'hDEAD;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .BUBBLE_DATA(BUBBLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [CTRL_W-1:0] ctl_of(input logic [DATA_W-1:0] d);
        return d[7:0] ^ 8'hA5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_data  = d;
        in_ctrl  = ctl_of(d);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 16'h0077);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [DATA_W-1:0] d);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        check_eq({tag, "_data"}, {16'b0, out_data}, {16'b0, d});
        check_eq({tag, "_ctrl"}, {24'b0, out_ctrl}, v ? {24'b0, ctl_of(d)} : 32'h0);
    endtask

    initial begin
        // Reset with in_valid held high
        do_reset();
        check_out("reset", 1'b0, BUBBLE);
        check_eq("reset_in_ready", {31'b0, in_ready}, 32'h1);
        check_eq("reset_stall", {28'b0, stall_cnt}, 32'h0);
        check_eq("reset_state", {30'b0, dbg_state}, 32'h0);

        // Streaming 1..8 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DATA_W'(i));
            tick();
            check_out("stream", 1'b1, DATA_W'(i));
            check_eq("stream_in_ready", {31'b0, in_ready}, 32'h1);
        end
        drive(1'b0, 16'h0000);
        tick();
        check_out("stream_drain", 1'b0, BUBBLE);
        check_eq("stream_stall", {28'b0, stall_cnt}, 32'h0);

        // Back-pressure: A, B, C
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 16'h00A1);
        tick();
        check_out("bp_a", 1'b1, 16'h00A1);
        out_ready = 1'b0;
        drive(1'b1, 16'h00B2);
        tick();
        check_out("bp_hold_a", 1'b1, 16'h00A1);
        check_eq("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
        check_eq("bp_state_full", {30'b0, dbg_state}, 32'h3);
        drive(1'b1, 16'h00C3);
        tick();
        tick();
        check_out("bp_still_a", 1'b1, 16'h00A1);
        check_eq("bp_stall3", {28'b0, stall_cnt}, 32'h3);
        out_ready = 1'b1;
        tick();
        check_out("bp_b", 1'b1, 16'h00B2);
        check_eq("bp_in_ready_back", {31'b0, in_ready}, 32'h1);
        tick();
        check_out("bp_c", 1'b1, 16'h00C3);
        drive(1'b0, 16'h0000);
        tick();
        check_out("bp_empty", 1'b0, BUBBLE);
        check_eq("bp_stall_final", {28'b0, stall_cnt}, 32'h3);

        // Flush while FULL, with D presented
        do_reset();
        drive(1'b1, 16'h0011);
        tick();
        drive(1'b1, 16'h0022);
        tick();
        check_eq("fl_in_ready_low", {31'b0, in_ready}, 32'h0);
        flush = 1'b1;
        drive(1'b1, 16'h00DD);
        tick();
        flush = 1'b0;
        check_out("fl_bubble", 1'b0, BUBBLE);
        check_eq("fl_in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        drive(1'b1, 16'h00EE);
        tick();
        check_out("fl_e", 1'b1, 16'h00EE);
        drive(1'b0, 16'h0000);
        tick();
        check_out("fl_empty", 1'b0, BUBBLE);
        check_eq("fl_stall", {28'b0, stall_cnt}, 32'h2);

        // Freeze in ONE with out_ready toggling
        do_reset();
        drive(1'b1, 16'h0055);
        tick();
        en = 1'b0;
        drive(1'b1, 16'h0066);
        for (int i = 0; i < 5; i++) begin
            out_ready = i[0];
            tick();
            check_out("frz", 1'b1, 16'h0055);
            check_eq("frz_stall", {28'b0, stall_cnt}, 32'h0);
            check_eq("frz_in_ready", {31'b0, in_ready}, 32'h1);
        end
        en = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000);
        tick();
        check_out("frz_resume", 1'b1, 16'h0055);
        check_eq("frz_resume_stall", {28'b0, stall_cnt}, 32'h1);
        out_ready = 1'b1;
        tick();
        check_out("frz_drain", 1'b0, BUBBLE);

        // Stall counter saturation
        do_reset();
        drive(1'b1, 16'h0012);
        tick();
        drive(1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_stall", {28'b0, stall_cnt}, 32'hF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("sat_after_flush", {28'b0, stall_cnt}, 32'hF);
        check_out("sat_flush_out", 1'b0, BUBBLE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("sat_after_rst", {28'b0, stall_cnt}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
